// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. Lookup in IF is purely combinational. Training happens at the
// rising edge from the resolved control-flow instruction in EX. EX also
// produces the mispredict/redirect decision and two performance counters.
module branch_predictor_btb #(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 32
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic [31:0]       if_pc,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    input  logic              ex_valid,
    input  logic [31:0]       ex_pc,
    input  logic              ex_is_branch,
    input  logic              ex_is_jump,
    input  logic              ex_taken,
    input  logic [31:0]       ex_target,
    input  logic              ex_pred_taken,
    input  logic [31:0]       ex_pred_target,
    output logic              mispredict,
    output logic [31:0]       redirect_pc,
    output logic [STAT_W-1:0] stat_ctrl,
    output logic [STAT_W-1:0] stat_miss
);
    localparam int IDX_W = $clog2(ENTRIES);

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_WT   = CNT_W'(1 << (CNT_W - 1));
    localparam logic [CNT_W-1:0]  CNT_WNT  = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

    // Table storage; target keeps only the word-aligned bits [31:2].
    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic              jump_q   [ENTRIES];
    logic [29:0]       target_q [ENTRIES];
    logic [CNT_W-1:0]  cnt_q    [ENTRIES];

    logic [STAT_W-1:0] stat_ctrl_q, stat_ctrl_d;
    logic [STAT_W-1:0] stat_miss_q, stat_miss_d;

    // IF lookup
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;

    assign if_idx      = if_pc[IDX_W+1:2];
    assign if_tag      = if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    // Jumps are always predicted taken on a hit, whatever the counter says.
    assign pred_taken  = if_hit && (jump_q[if_idx] || cnt_q[if_idx][CNT_W-1]);
    assign pred_target = pred_taken ? {target_q[if_idx], 2'b00} : (if_pc + 32'd4);

    // EX resolution
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic             ex_ctrl;
    logic             ex_actual;
    logic [31:0]      ex_next_pc;

    assign ex_idx     = ex_pc[IDX_W+1:2];
    assign ex_tag     = ex_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign ex_ctrl    = ex_is_branch | ex_is_jump;
    assign ex_actual  = ex_taken & ex_ctrl;
    assign ex_next_pc = ex_actual ? ex_target : (ex_pc + 32'd4);

    // A wrong direction, or a right "taken" with the wrong target, both redirect.
    assign mispredict  = ex_valid &&
                         ((ex_pred_taken != ex_actual) ||
                          (ex_actual && (ex_pred_target != ex_target)));
    assign redirect_pc = ex_valid ? ex_next_pc : 32'd0;

    assign stat_ctrl = stat_ctrl_q;
    assign stat_miss = stat_miss_q;

    // Training write for the entry addressed by ex_pc
    logic             wr_en;
    logic             wr_valid;
    logic [TAG_W-1:0] wr_tag;
    logic             wr_jump;
    logic [29:0]      wr_target;
    logic [CNT_W-1:0] wr_cnt;

    // Decide whether and how the EX instruction rewrites its table entry.
    always_comb begin
        wr_en     = 1'b0;
        wr_valid  = valid_q[ex_idx];
        wr_tag    = tag_q[ex_idx];
        wr_jump   = jump_q[ex_idx];
        wr_target = target_q[ex_idx];
        wr_cnt    = cnt_q[ex_idx];
        if (ex_valid) begin
            if (ex_ctrl && ex_hit) begin
                wr_en = 1'b1;
                if (ex_actual) begin
                    if (cnt_q[ex_idx] != CNT_MAX) begin
                        wr_cnt = cnt_q[ex_idx] + CNT_ONE;
                    end
                    wr_target = ex_target[31:2];
                    wr_jump   = ex_is_jump;
                end else if (cnt_q[ex_idx] != '0) begin
                    wr_cnt = cnt_q[ex_idx] - CNT_ONE;
                end
            end else if (ex_ctrl && ex_actual) begin
                // Fresh allocation (or replacement of a different tag).
                wr_en     = 1'b1;
                wr_valid  = 1'b1;
                wr_tag    = ex_tag;
                wr_jump   = ex_is_jump;
                wr_target = ex_target[31:2];
                wr_cnt    = CNT_WT;
            end else if (!ex_ctrl && ex_hit) begin
                // Entry matched a non-control instruction: stale or aliased, drop it.
                wr_en    = 1'b1;
                wr_valid = 1'b0;
            end
        end
    end

    // Saturating performance counters, advanced only by real EX instructions.
    always_comb begin
        stat_ctrl_d = stat_ctrl_q;
        stat_miss_d = stat_miss_q;
        if (ex_valid && ex_ctrl && (stat_ctrl_q != '1)) begin
            stat_ctrl_d = stat_ctrl_q + STAT_ONE;
        end
        if (mispredict && (stat_miss_q != '1)) begin
            stat_miss_d = stat_miss_q + STAT_ONE;
        end
    end

    // Table state: async clear to invalid/weak-not-taken, single-entry write per cycle.
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                jump_q[i]   <= 1'b0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_WNT;
            end
        end else if (wr_en) begin
            valid_q[ex_idx]  <= wr_valid;
            tag_q[ex_idx]    <= wr_tag;
            jump_q[ex_idx]   <= wr_jump;
            target_q[ex_idx] <= wr_target;
            cnt_q[ex_idx]    <= wr_cnt;
        end
    end

    // Statistics registers.
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            stat_ctrl_q <= '0;
            stat_miss_q <= '0;
        end else begin
            stat_ctrl_q <= stat_ctrl_d;
            stat_miss_q <= stat_miss_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Bench for branch_predictor_btb: an abstract table model checked every
// negative clock edge, plus directed scenarios with literal expectations.
module tb_branch_predictor_btb;
    localparam int ENT  = 16;
    localparam int IW   = 4;
    localparam int TW   = 8;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;
    localparam int WT   = 1 << (CW - 1);
    localparam int WNT  = WT - 1;

    logic        cpu_clk;
    logic        cpu_rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] stat_ctrl;
    logic [31:0] stat_miss;

    branch_predictor_btb #(
        .ENTRIES(ENT), .TAG_W(TW), .CNT_W(CW), .STAT_W(32)
    ) dut (
        .cpu_clk       (cpu_clk),
        .cpu_rst       (cpu_rst),
        .if_pc         (if_pc),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_is_branch  (ex_is_branch),
        .ex_is_jump    (ex_is_jump),
        .ex_taken      (ex_taken),
        .ex_target     (ex_target),
        .ex_pred_taken (ex_pred_taken),
        .ex_pred_target(ex_pred_target),
        .mispredict    (mispredict),
        .redirect_pc   (redirect_pc),
        .stat_ctrl     (stat_ctrl),
        .stat_miss     (stat_miss)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    int errors  = 0;
    int checks  = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_valid  [ENT];
    int          m_tag    [ENT];
    bit          m_jump   [ENT];
    logic [31:0] m_target [ENT];
    int          m_cnt    [ENT];
    logic [31:0] m_ctrl;
    logic [31:0] m_miss;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENT);
    endfunction

    function automatic int tag_of(input logic [31:0] pc);
        return int'((pc >> (2 + IW)) % (1 << TW));
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit exp_actual();
        return ex_taken && (ex_is_branch || ex_is_jump);
    endfunction

    function automatic bit exp_mis();
        bit a;
        a = exp_actual();
        return ex_valid && ((ex_pred_taken != a) || (a && (ex_pred_target != ex_target)));
    endfunction

    // Training and statistics, mirroring the architectural rules.
    always @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            for (int i = 0; i < ENT; i++) begin
                m_valid[i] = 1'b0;
                m_cnt[i]   = WNT;
                m_jump[i]  = 1'b0;
                m_tag[i]   = 0;
                m_target[i] = 32'd0;
            end
            m_ctrl = 32'd0;
            m_miss = 32'd0;
        end else if (ex_valid) begin
            bit ctrl;
            bit act;
            bit hit;
            int i;
            ctrl = ex_is_branch || ex_is_jump;
            act  = exp_actual();
            hit  = m_hit(ex_pc);
            i    = idx_of(ex_pc);
            if (exp_mis()) m_miss = m_miss + 1;
            if (ctrl) m_ctrl = m_ctrl + 1;
            if (ctrl && hit) begin
                if (act) begin
                    m_cnt[i]    = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
                    m_target[i] = ex_target & 32'hFFFF_FFFC;
                    m_jump[i]   = ex_is_jump;
                end else begin
                    m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
                end
            end else if (ctrl && act) begin
                m_valid[i]  = 1'b1;
                m_tag[i]    = tag_of(ex_pc);
                m_target[i] = ex_target & 32'hFFFF_FFFC;
                m_jump[i]   = ex_is_jump;
                m_cnt[i]    = WT;
            end else if (!ctrl && hit) begin
                m_valid[i] = 1'b0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge cpu_clk) begin
        if (started) begin
            bit          e_tk;
            logic [31:0] e_tg;
            logic [31:0] e_rd;
            int          i;
            i    = idx_of(if_pc);
            e_tk = m_hit(if_pc) && (m_jump[i] || (m_cnt[i] >= WT));
            e_tg = e_tk ? m_target[i] : if_pc + 32'd4;
            e_rd = !ex_valid ? 32'd0 : (exp_actual() ? ex_target : ex_pc + 32'd4);
            chk("model_pred_taken", {31'd0, pred_taken}, {31'd0, e_tk});
            chk("model_pred_target", pred_target, e_tg);
            chk("model_mispredict", {31'd0, mispredict}, {31'd0, exp_mis()});
            chk("model_redirect_pc", redirect_pc, e_rd);
            chk("model_stat_ctrl", stat_ctrl, m_ctrl);
            chk("model_stat_miss", stat_miss, m_miss);
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_ex(input logic v, input logic [31:0] pc, input logic br, input logic j,
                          input logic tk, input logic [31:0] tgt, input logic ptk,
                          input logic [31:0] ptgt);
        ex_valid       = v;
        ex_pc          = pc;
        ex_is_branch   = br;
        ex_is_jump     = j;
        ex_taken       = tk;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
    endtask

    task automatic idle_ex();
        set_ex(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    initial begin
        cpu_rst = 1'b1;
        if_pc   = 32'h100;
        idle_ex();
        #2 cpu_rst = 1'b0;
        started = 1'b1;
        #1;
        // 1: reset state
        chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("rst_pred_target", pred_target, 32'h104);
        chk("rst_stat_ctrl", stat_ctrl, 32'd0);
        chk("rst_stat_miss", stat_miss, 32'd0);
        #9 cpu_rst = 1'b1;
        tick();

        // 2: first taken branch allocates
        set_ex(1, 32'h200, 1, 0, 1, 32'h180, 0, 32'h204);
        #1;
        chk("t2_mispredict", {31'd0, mispredict}, 32'd1);
        chk("t2_redirect", redirect_pc, 32'h180);
        tick();
        idle_ex();
        if_pc = 32'h200;
        #1;
        chk("t2_pred_taken", {31'd0, pred_taken}, 32'd1);
        chk("t2_pred_target", pred_target, 32'h180);
        chk("t2_stat_ctrl", stat_ctrl, 32'd1);
        chk("t2_stat_miss", stat_miss, 32'd1);

        // 3: two not-taken resolutions walk the counter down
        set_ex(1, 32'h200, 1, 0, 0, 32'h180, 1, 32'h180);
        #1;
        chk("t3a_mispredict", {31'd0, mispredict}, 32'd1);
        chk("t3a_redirect", redirect_pc, 32'h204);
        tick();
        idle_ex();
        #1;
        chk("t3a_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("t3a_pred_target", pred_target, 32'h204);
        set_ex(1, 32'h200, 1, 0, 0, 32'h180, 0, 32'h204);
        #1;
        chk("t3b_mispredict", {31'd0, mispredict}, 32'd0);
        chk("t3b_redirect", redirect_pc, 32'h204);
        tick();
        idle_ex();
        #1;
        chk("t3b_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("t3b_stat_ctrl", stat_ctrl, 32'd3);
        chk("t3b_stat_miss", stat_miss, 32'd2);
        // counter floor: one more not-taken stays at 0, then one taken reaches 1
        set_ex(1, 32'h200, 1, 0, 0, 32'h180, 0, 32'h204);
        tick();
        set_ex(1, 32'h200, 1, 0, 1, 32'h180, 0, 32'h204);
        tick();
        idle_ex();
        #1;
        chk("t3c_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("t3c_stat_ctrl", stat_ctrl, 32'd5);
        chk("t3c_stat_miss", stat_miss, 32'd3);

        // 4: jal keeps predicting taken even with counter at 0
        if_pc = 32'h300;
        set_ex(1, 32'h300, 0, 1, 1, 32'h400, 0, 32'h304);
        #1;
        chk("t4_alloc_mispredict", {31'd0, mispredict}, 32'd1);
        chk("t4_alloc_redirect", redirect_pc, 32'h400);
        tick();
        idle_ex();
        #1;
        chk("t4_pred_taken", {31'd0, pred_taken}, 32'd1);
        chk("t4_pred_target", pred_target, 32'h400);
        for (int k = 0; k < 2; k++) begin
            set_ex(1, 32'h300, 0, 1, 0, 32'h400, 1, 32'h400);
            #1;
            chk("t4_nt_redirect", redirect_pc, 32'h304);
            tick();
        end
        idle_ex();
        #1;
        chk("t4_cnt0_pred_taken", {31'd0, pred_taken}, 32'd1);
        chk("t4_cnt0_pred_target", pred_target, 32'h400);
        set_ex(1, 32'h300, 0, 1, 1, 32'h400, 1, 32'h404);
        #1;
        chk("t4_tgt_mispredict", {31'd0, mispredict}, 32'd1);
        chk("t4_tgt_redirect", redirect_pc, 32'h400);
        tick();
        idle_ex();
        #1;
        chk("t4_stat_ctrl", stat_ctrl, 32'd9);
        chk("t4_stat_miss", stat_miss, 32'd7);

        // 5: non-branch at an aliasing PC invalidates the entry
        set_ex(1, 32'h4300, 0, 0, 0, 32'd0, 1, 32'h400);
        #1;
        chk("t5_mispredict", {31'd0, mispredict}, 32'd1);
        chk("t5_redirect", redirect_pc, 32'h4304);
        tick();
        idle_ex();
        #1;
        chk("t5_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("t5_pred_target", pred_target, 32'h304);
        chk("t5_stat_ctrl", stat_ctrl, 32'd9);
        chk("t5_stat_miss", stat_miss, 32'd8);

        // 6: asynchronous reset between edges after a fill
        set_ex(1, 32'h548, 0, 1, 1, 32'h600, 0, 32'h54C);
        tick();
        idle_ex();
        if_pc = 32'h548;
        #1;
        chk("t6_fill_pred_taken", {31'd0, pred_taken}, 32'd1);
        #1 cpu_rst = 1'b0;
        #1;
        chk("t6_rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("t6_rst_pred_target", pred_target, 32'h54C);
        chk("t6_rst_stat_ctrl", stat_ctrl, 32'd0);
        chk("t6_rst_stat_miss", stat_miss, 32'd0);
        if_pc = 32'h200;
        #2;
        chk("t6_rst_pred_target2", pred_target, 32'h204);
        set_ex(0, 32'h548, 1, 0, 1, 32'h700, 0, 32'h54C);
        #1 cpu_rst = 1'b1;
        #1;
        chk("t6_inv_mispredict", {31'd0, mispredict}, 32'd0);
        chk("t6_inv_redirect", redirect_pc, 32'd0);
        tick();
        if_pc = 32'h548;
        #1;
        chk("t6_inv_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("t6_inv_stat_ctrl", stat_ctrl, 32'd0);
        idle_ex();

        // 7: counter saturates at max instead of wrapping
        set_ex(1, 32'h700, 1, 0, 1, 32'h740, 0, 32'h704);
        tick();
        for (int k = 0; k < 2; k++) begin
            set_ex(1, 32'h700, 1, 0, 1, 32'h740, 1, 32'h740);
            tick();
        end
        set_ex(1, 32'h700, 1, 0, 0, 32'h740, 1, 32'h740);
        tick();
        idle_ex();
        if_pc = 32'h700;
        #1;
        chk("t7_pred_taken", {31'd0, pred_taken}, 32'd1);
        chk("t7_pred_target", pred_target, 32'h740);

        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
